// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state type,
// the halt encoding, default geometry and the opcode field position.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [8:0] HALT_INSTR = 9'h1FF;

    localparam int PC_W_DEF   = 10;
    localparam int LUT_AW_DEF = 4;

    // Opcode field of the 9-bit instruction, consumed by the decoder.
    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;

endpackage

// File: rtl/branch_lut.sv
// Writable branch-target table: one synchronous write port, one
// combinational read port. Write gating is decided by the parent.
module branch_lut #(
    parameter int LUT_AW = 4,
    parameter int PC_W   = 10
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [LUT_AW-1:0] waddr,
    input  logic [PC_W-1:0]   wdata,
    input  logic [LUT_AW-1:0] raddr,
    output logic [PC_W-1:0]   rdata
);

    logic [PC_W-1:0] mem [2**LUT_AW];

    // Store a branch target on a write strobe.
    // NOTE: the table has no reset; entries are meaningful only once written,
    // and leaving it unreset lets it map onto plain storage.
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: program counter, start/run/halt sequencing and
// single-cycle branch resolution through the branch LUT.
// Optional feature: define FETCH_CYCLE_CT_EN to add the saturating CycleCt
// counter of edges spent in RUN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [8:0]        Instr,
    input  logic              BranchEn,
    input  logic              Taken,
    input  logic              LutWen,
    input  logic [LUT_AW-1:0] LutAddr,
    input  logic [PC_W-1:0]   LutData,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Running,
    output logic              Done
`ifdef FETCH_CYCLE_CT_EN
    ,
    output logic [15:0]       CycleCt
`endif
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t    state;
    logic [PC_W-1:0] branch_target;
    logic            lut_wen;

    // The table is only writable while no program is executing.
    assign lut_wen = LutWen && (state != RUN);

    branch_lut #(
        .LUT_AW (LUT_AW),
        .PC_W   (PC_W)
    ) u_lut (
        .clk   (Clk),
        .wen   (lut_wen),
        .waddr (LutAddr),
        .wdata (LutData),
        .raddr (Instr[LUT_AW-1:0]),
        .rdata (branch_target)
    );

    // Sequencing FSM and next-PC selection; halt outranks a taken branch.
    always_ff @(posedge Clk) begin
        if (Reset || Start) begin
            state   <= IDLE;
            ProgCtr <= '0;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    if (Instr == HALT_INSTR) begin
                        state <= HALT;
                    end else if (BranchEn && Taken) begin
                        ProgCtr <= branch_target;
                    end else begin
                        ProgCtr <= ProgCtr + PC_ONE;
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    assign Running = (state == RUN);
    assign Done    = (state == HALT);

`ifdef FETCH_CYCLE_CT_EN
    // Count edges spent in RUN, saturating at all ones.
    always_ff @(posedge Clk) begin
        if (Reset || Start) begin
            CycleCt <= '0;
        end else if (state == RUN && CycleCt != 16'hFFFF) begin
            CycleCt <= CycleCt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a ROM/decoder stand-in table, a program-level
// reference model compared every cycle, and directed literal expectations.
module tb_instr_fetch;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [8:0] Instr;
    logic       BranchEn;
    logic       Taken;
    logic       LutWen;
    logic [3:0] LutAddr;
    logic [9:0] LutData;
    logic [9:0] ProgCtr;
    logic       Running;
    logic       Done;
`ifdef FETCH_CYCLE_CT_EN
    logic [15:0] CycleCt;
`endif

    always #5 Clk = ~Clk;

    // ROM word plus the decoder/ALU response for that address.
    typedef struct packed {
        logic [8:0] instr;
        logic       br;
        logic       tk;
    } rom_t;

    rom_t rom [1024];

    assign Instr    = rom[ProgCtr].instr;
    assign BranchEn = rom[ProgCtr].br;
    assign Taken    = rom[ProgCtr].tk;

    instr_fetch dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Instr    (Instr),
        .BranchEn (BranchEn),
        .Taken    (Taken),
        .LutWen   (LutWen),
        .LutAddr  (LutAddr),
        .LutData  (LutData),
        .ProgCtr  (ProgCtr),
        .Running  (Running),
        .Done     (Done)
`ifdef FETCH_CYCLE_CT_EN
        ,
        .CycleCt  (CycleCt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;

    mode_t      m_mode = M_IDLE;
    mode_t      m_prev;
    int         m_pc   = 0;
    int         m_ct   = 0;
    bit         m_valid = 1'b0;
    logic [9:0] m_lut [16];
    rom_t       m_word;

    always @(posedge Clk) begin
        m_prev = m_mode;
        if (LutWen && m_prev != M_RUN) m_lut[LutAddr] = LutData;
        if (Reset || Start) begin
            m_mode  = M_IDLE;
            m_pc    = 0;
            m_ct    = 0;
            m_valid = 1'b1;
        end else if (m_prev == M_IDLE) begin
            m_mode = M_RUN;
        end else if (m_prev == M_RUN) begin
            m_word = rom[m_pc];
            if (m_ct < 65535) m_ct = m_ct + 1;
            if (m_word.instr == 9'h1FF) m_mode = M_HALT;
            else if (m_word.br && m_word.tk) m_pc = int'(m_lut[m_word.instr[3:0]]);
            else m_pc = (m_pc + 1) % 1024;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (m_valid) begin
            check("model_pc", 32'(ProgCtr), 32'(m_pc));
            check("model_running", 32'(Running), 32'(m_mode == M_RUN));
            check("model_done", 32'(Done), 32'(m_mode == M_HALT));
`ifdef FETCH_CYCLE_CT_EN
            check("model_cyclect", 32'(CycleCt), 32'(m_ct));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = '0;
    endtask

    task automatic lut_write(input logic [3:0] addr, input logic [9:0] data);
        LutWen  = 1'b1;
        LutAddr = addr;
        LutData = data;
        tick();
        LutWen  = 1'b0;
    endtask

    initial begin
        Reset   = 1'b1;
        Start   = 1'b0;
        LutWen  = 1'b0;
        LutAddr = '0;
        LutData = '0;
        clear_rom();

        // Reset held for two cycles, then released with Start low.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_pc", 32'(ProgCtr), 32'h0);
            check("rst_running", 32'(Running), 32'h0);
            check("rst_done", 32'(Done), 32'h0);
        end
        Reset = 1'b0;
        tick();
        check("rst_release_running", 32'(Running), 32'h1);
        check("rst_release_pc", 32'(ProgCtr), 32'h0);

        // Sequential run 0..5 with halt at 5.
        Start = 1'b1;
        tick();
        rom[5] = '{9'h1FF, 1'b0, 1'b0};
        Start = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            check("seq_pc", 32'(ProgCtr), 32'(i));
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            check("halt_done", 32'(Done), 32'h1);
            check("halt_pc", 32'(ProgCtr), 32'h5);
            tick();
        end
`ifdef FETCH_CYCLE_CT_EN
        check("seq_cyclect", 32'(CycleCt), 32'd6);
`endif

        // Fill LUT entries while held idle.
        Start = 1'b1;
        lut_write(4'd3, 10'h040);
        lut_write(4'd1, 10'h155);
        lut_write(4'd2, 10'h3FE);

        // Taken branch at PC 2 via LUT[3].
        clear_rom();
        rom[2]     = '{9'h0C3, 1'b1, 1'b1};
        rom[10'h040] = '{9'h1FF, 1'b0, 1'b0};
        Start = 1'b0;
        tick();
        tick();
        tick();
        check("br_at_pc2", 32'(ProgCtr), 32'h2);
        tick();
        check("br_taken_pc", 32'(ProgCtr), 32'h040);
        tick();
        check("br_taken_halt", 32'(Done), 32'h1);

        // Same branch, condition false.
        Start = 1'b1;
        tick();
        rom[2].tk = 1'b0;
        rom[3]    = '{9'h1FF, 1'b0, 1'b0};
        Start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("br_not_taken_pc", 32'(ProgCtr), 32'h3);

        // Halt outranks a taken branch.
        Start = 1'b1;
        tick();
        clear_rom();
        rom[7] = '{9'h1FF, 1'b1, 1'b1};
        Start = 1'b0;
        tick();
        repeat (7) tick();
        check("hp_pc7", 32'(ProgCtr), 32'h7);
        tick();
        check("hp_done", 32'(Done), 32'h1);
        check("hp_pc_hold", 32'(ProgCtr), 32'h7);
        tick();
        check("hp_pc_hold2", 32'(ProgCtr), 32'h7);

        // LUT write attempted during RUN must be dropped.
        Start = 1'b1;
        tick();
        clear_rom();
        rom[4]       = '{9'h041, 1'b1, 1'b1};
        rom[10'h155] = '{9'h1FF, 1'b0, 1'b0};
        Start = 1'b0;
        tick();
        tick();
        lut_write(4'd1, 10'h3FF);
        tick();
        tick();
        check("blk_pc4", 32'(ProgCtr), 32'h4);
        tick();
        check("blk_target", 32'(ProgCtr), 32'h155);

        // Reset and Start together; LUT survives reset.
        Reset = 1'b1;
        Start = 1'b1;
        tick();
        check("rs_pc", 32'(ProgCtr), 32'h0);
        check("rs_running", 32'(Running), 32'h0);
        Reset = 1'b0;
        clear_rom();
        rom[0] = '{9'h002, 1'b1, 1'b1};
        Start = 1'b0;
        tick();
        tick();
        check("wrap_3fe", 32'(ProgCtr), 32'h3FE);
        tick();
        check("wrap_3ff", 32'(ProgCtr), 32'h3FF);
        tick();
        check("wrap_zero", 32'(ProgCtr), 32'h0);

        // Mid-run restart at PC 0x12 discards a pending taken branch.
        Start = 1'b1;
        tick();
        clear_rom();
        rom[10'h012] = '{9'h003, 1'b1, 1'b1};
        Start = 1'b0;
        tick();
        repeat (18) tick();
        check("mid_pc12", 32'(ProgCtr), 32'h12);
        Start = 1'b1;
        tick();
        check("mid_restart_pc", 32'(ProgCtr), 32'h0);
        check("mid_restart_running", 32'(Running), 32'h0);
        Start = 1'b0;
        tick();
        check("mid_rerun_running", 32'(Running), 32'h1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
